ipsxe_floating_point_invsqrt_result_buffer_v1_0: RTL and testbench

//  Downstream stage of the floating-point inverse square-root core. Captures each core result
//  (word + invalid_op + divide_by_zero flags) into a FIFO and presents it on a valid/ready

---
 rtl/ipsxe_floating_point_invsqrt_result_buffer_v1_0.sv | 127 ++++++++++++
 tb/tb_ipsxe_floating_point_invsqrt_result_buffer_v1_0.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_invsqrt_result_buffer_v1_0.sv
// Result FIFO behind the invsqrt core: captures word + flags, presents them on a
// valid/ready port, and hands out issue credit so a return can never find the FIFO full.
module ipsxe_floating_point_invsqrt_result_buffer_v1_0 #(
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52,
  parameter int DEPTH     = 16,
  localparam int DW = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_aclken,
  input  logic          i_issue,
  output logic          o_issue_ok,
  input  logic          i_res_valid,
  input  logic [DW-1:0] i_res_data,
  input  logic          i_res_invalid_op,
  input  logic          i_res_div_by_zero,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_invalid_op,
  output logic          o_divide_by_zero,
  output logic [CW-1:0] o_level,
  output logic [CW-1:0] o_inflight,
  output logic [1:0]    o_err
);

  localparam int EW = DW + 2;
  localparam logic [CW-1:0] DEPTH_LVL = DEPTH[CW-1:0];
  localparam logic [CW:0]   DEPTH_OCC = DEPTH[CW:0];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          invalid_op;
    logic          div_by_zero;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   level, inflight;
  logic [1:0]      err;

  logic            iss, ret, pop, full, wr, drop, ret_orphan;
  logic [CW:0]     occupancy;
  entry_t          head, wr_entry;

  // Credit counts both stored words and words still inside the core pipeline.
  assign occupancy  = {1'b0, inflight} + {1'b0, level};
  assign o_issue_ok = occupancy < DEPTH_OCC;

  assign iss        = i_issue & i_aclken & o_issue_ok;
  assign ret        = i_res_valid & i_aclken;
  assign pop        = o_valid & i_ready;
  assign full       = (level == DEPTH_LVL);
  assign wr         = ret & (~full | pop);
  assign drop       = ret & full & ~pop;
  assign ret_orphan = ret & (inflight == '0);

  assign wr_entry = '{data: i_res_data, invalid_op: i_res_invalid_op,
                      div_by_zero: i_res_div_by_zero};

  // Storage is deliberately unreset; o_valid gates everything read from it.
  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level <= '0;
    end else if (wr && !pop) begin
      level <= level + CW'(1);
    end else if (!wr && pop) begin
      level <= level - CW'(1);
    end
  end

  // A return with nothing outstanding is not subtracted; it only flags err[1].
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else if (iss && !ret) begin
      inflight <= inflight + CW'(1);
    end else if (ret && !iss && !ret_orphan) begin
      inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err <= '0;
    end else begin
      if (drop)       err[0] <= 1'b1;
      if (ret_orphan) err[1] <= 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign o_valid = (level != '0);

  always_comb begin
    o_data           = '0;
    o_invalid_op     = 1'b0;
    o_divide_by_zero = 1'b0;
    if (o_valid) begin
      o_data           = head.data;
      o_invalid_op     = head.invalid_op;
      o_divide_by_zero = head.div_by_zero;
    end
  end

  assign o_level    = level;
  assign o_inflight = inflight;
  assign o_err      = err;

endmodule

// File: tb/tb_ipsxe_floating_point_invsqrt_result_buffer_v1_0.sv
// Directed bench for the invsqrt result buffer: reset, credit, full, clock-enable, ordering.
module tb_ipsxe_floating_point_invsqrt_result_buffer_v1_0;

  localparam int DW = 64;
  localparam int CW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst, i_aclken, i_issue, i_res_valid;
  logic [DW-1:0] i_res_data;
  logic          i_res_invalid_op, i_res_div_by_zero, i_ready;
  logic          o_issue_ok, o_valid, o_invalid_op, o_divide_by_zero;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_level, o_inflight;
  logic [1:0]    o_err;

  int checks = 0;
  int failures = 0;

  ipsxe_floating_point_invsqrt_result_buffer_v1_0 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_aclken(i_aclken), .i_issue(i_issue),
    .o_issue_ok(o_issue_ok), .i_res_valid(i_res_valid), .i_res_data(i_res_data),
    .i_res_invalid_op(i_res_invalid_op), .i_res_div_by_zero(i_res_div_by_zero),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_invalid_op(o_invalid_op), .o_divide_by_zero(o_divide_by_zero),
    .o_level(o_level), .o_inflight(o_inflight), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ret_word(input logic [63:0] d, input logic inv, input logic dbz);
    i_res_valid = 1'b1; i_res_data = d; i_res_invalid_op = inv; i_res_div_by_zero = dbz;
    step();
    i_res_valid = 1'b0; i_res_data = '0; i_res_invalid_op = 1'b0; i_res_div_by_zero = 1'b0;
  endtask

  logic [63:0] exp_d [2];
  logic        exp_inv [2];
  logic        exp_dbz [2];
  int          idx;

  initial begin
    i_rst = 1'b1; i_aclken = 1'b1; i_issue = 1'b0; i_res_valid = 1'b0;
    i_res_data = '0; i_res_invalid_op = 1'b0; i_res_div_by_zero = 1'b0; i_ready = 1'b1;

    // 1: reset
    step(); step();
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_level", o_level, 0);
    check("rst_inflight", o_inflight, 0);
    check("rst_issue_ok", o_issue_ok, 1);
    check("rst_err", o_err, 0);
    check("rst_data", o_data, 0);

    // 2: single op
    i_ready = 1'b0;
    i_issue = 1'b1; step(); i_issue = 1'b0;
    check("s_inflight1", o_inflight, 1);
    check("s_valid_pre", o_valid, 0);
    ret_word(64'h3FE0000000000000, 1'b0, 1'b0);
    check("s_valid", o_valid, 1);
    check("s_data", o_data, 64'h3FE0000000000000);
    check("s_flags", {o_invalid_op, o_divide_by_zero}, 0);
    check("s_inflight0", o_inflight, 0);
    step();
    check("s_stall_data", o_data, 64'h3FE0000000000000);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    check("s_pop_level", o_level, 0);
    check("s_pop_valid", o_valid, 0);
    check("s_pop_data", o_data, 0);

    // 3: credit limit
    for (int k = 0; k < 16; k++) begin
      i_issue = 1'b1; step();
    end
    check("c_inflight16", o_inflight, 16);
    check("c_issue_ok0", o_issue_ok, 0);
    step();  // issue held while credit is exhausted is not counted
    i_issue = 1'b0;
    check("c_no_over", o_inflight, 16);
    for (int k = 0; k < 16; k++) ret_word(64'h100 + 64'(k), 1'b0, 1'b0);
    check("c_level16", o_level, 16);
    check("c_inflight0", o_inflight, 0);
    check("c_err0", o_err, 0);
    check("c_ok_full", o_issue_ok, 0);
    check("c_head", o_data, 64'h100);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    check("c_level15", o_level, 15);
    check("c_ok_back", o_issue_ok, 1);
    check("c_head2", o_data, 64'h101);

    // 4: full with simultaneous write/pop, then drop
    i_issue = 1'b1; step(); i_issue = 1'b0;
    ret_word(64'h200, 1'b0, 1'b0);
    check("f_level16", o_level, 16);
    i_ready = 1'b1;
    ret_word(64'h201, 1'b0, 1'b0);
    i_ready = 1'b0;
    check("f_wp_level", o_level, 16);
    check("f_wp_head", o_data, 64'h102);
    check("f_wp_err", o_err, 2'b10);
    ret_word(64'h202, 1'b0, 1'b0);
    check("f_drop_err", o_err, 2'b11);
    check("f_drop_level", o_level, 16);
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("f_drain", o_data, (k < 14) ? 64'h102 + 64'(k) : 64'h200 + 64'(k - 14));
      step();
    end
    i_ready = 1'b0;
    check("f_empty", o_valid, 0);

    // 5: clock-enable gating
    i_issue = 1'b1; step(); step(); i_issue = 1'b0;
    ret_word(64'h300, 1'b0, 1'b0);
    check("a_pre_inflight", o_inflight, 1);
    check("a_pre_level", o_level, 1);
    i_aclken = 1'b0; i_issue = 1'b1; i_res_valid = 1'b1; i_res_data = 64'hDEAD;
    for (int k = 0; k < 5; k++) step();
    check("a_inflight", o_inflight, 1);
    check("a_level", o_level, 1);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    check("a_pop_level", o_level, 0);
    i_issue = 1'b0; i_res_valid = 1'b0; i_res_data = '0; i_aclken = 1'b1;
    ret_word(64'h301, 1'b0, 1'b0);
    check("a_ret_inflight", o_inflight, 0);
    check("a_ret_data", o_data, 64'h301);
    i_ready = 1'b1; step(); i_ready = 1'b0;

    // 6: flags and ordering under random stall
    exp_d[0] = 64'h7FF8000000000000; exp_inv[0] = 1'b1; exp_dbz[0] = 1'b0;
    exp_d[1] = 64'h7FF0000000000000; exp_inv[1] = 1'b0; exp_dbz[1] = 1'b1;
    i_issue = 1'b1; step(); step(); i_issue = 1'b0;
    ret_word(exp_d[0], 1'b1, 1'b0);
    ret_word(exp_d[1], 1'b0, 1'b1);
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 2; cyc++) begin
      i_ready = 1'($urandom_range(0, 1));
      if (o_valid && i_ready) begin
        check("o_data", o_data, exp_d[idx]);
        check("o_flags", {o_invalid_op, o_divide_by_zero}, {exp_inv[idx], exp_dbz[idx]});
        idx++;
      end
      step();
    end
    i_ready = 1'b0;
    check("o_count", idx, 2);
    check("o_empty", o_level, 0);

    // reset mid-operation: a late return still lands and flags err[1]
    i_issue = 1'b1; step(); i_issue = 1'b0;
    i_rst = 1'b1; step(); i_rst = 1'b0;
    check("r_err_clr", o_err, 0);
    check("r_inflight", o_inflight, 0);
    ret_word(64'h400, 1'b0, 1'b0);
    check("r_level", o_level, 1);
    check("r_data", o_data, 64'h400);
    check("r_err1", o_err, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
